fetch_sequencer: RTL

//  Controls the IF stage: owns PCF, runs a req/ack handshake to a variable-latency instruction memory, and owns the IF/ID register.

---
 rtl/fetch_sequencer_if.sv | 10 +
 rtl/fetch_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and imem.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// IF-stage sequencer: owns PCF, fetches over a req/ack bus with one fetch in flight,
// and loads the IF/ID register, honouring redirects, decode stalls and flushes.
//
// state  | meaning
// S_IDLE | first cycle after reset, no request
// S_REQ  | request for PCF on the bus
// S_HOLD | fetched word parked in skid while decode is stalled
// S_DROP | stale fetch still in flight; its data is discarded
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pcsrc,
  input  logic [31:0]        pctarget,
  input  logic               stall_d,
  input  logic               flush_d,
  fetch_sequencer_if.master  imem,
  output logic [31:0]        instrd,
  output logic [31:0]        pcd,
  output logic [31:0]        pcplus4D,
  output logic               valid_d
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} state_t;

  state_t      state, state_n;
  logic [31:0] pcf, pcf_n;
  logic [31:0] drop_addr, drop_addr_n;
  logic [31:0] skid_instr, skid_instr_n;
  logic [31:0] skid_pc, skid_pc_n;
  logic [31:0] instrd_n, pcd_n, pcplus4_n;
  logic        valid_n;
  logic [31:0] target;

  assign target = {pctarget[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pcf        <= RESET_PC;
      drop_addr  <= RESET_PC;
      skid_instr <= '0;
      skid_pc    <= '0;
      instrd     <= BUBBLE;
      pcd        <= '0;
      pcplus4D   <= '0;
      valid_d    <= 1'b0;
    end else begin
      state      <= state_n;
      pcf        <= pcf_n;
      drop_addr  <= drop_addr_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
      instrd     <= instrd_n;
      pcd        <= pcd_n;
      pcplus4D   <= pcplus4_n;
      valid_d    <= valid_n;
    end
  end

  always_comb begin
    state_n        = state;
    pcf_n          = pcf;
    drop_addr_n    = drop_addr;
    skid_instr_n   = skid_instr;
    skid_pc_n      = skid_pc;
    instrd_n       = instrd;
    pcd_n          = pcd;
    pcplus4_n      = pcplus4D;
    valid_n        = valid_d;
    imem.imem_req  = 1'b0;
    imem.imem_addr = pcf;

    case (state)
      S_IDLE: begin
        state_n = S_REQ;
        if (pcsrc) pcf_n = target;
      end
      S_REQ: begin
        imem.imem_req = 1'b1;
        if (pcsrc) begin
          pcf_n = target;
          if (!imem.imem_ack) begin
            drop_addr_n = pcf;
            state_n     = S_DROP;
          end
        end else if (imem.imem_ack) begin
          pcf_n = pcf + 32'd4;
          if (stall_d) begin
            skid_instr_n = imem.imem_rdata;
            skid_pc_n    = pcf;
            state_n      = S_HOLD;
          end else begin
            instrd_n  = imem.imem_rdata;
            pcd_n     = pcf;
            pcplus4_n = pcf + 32'd4;
            valid_n   = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (pcsrc) begin
          pcf_n   = target;
          state_n = S_REQ;
        end else if (flush_d) begin
          state_n = S_REQ;
        end else if (!stall_d) begin
          instrd_n  = skid_instr;
          pcd_n     = skid_pc;
          pcplus4_n = skid_pc + 32'd4;
          valid_n   = 1'b1;
          state_n   = S_REQ;
        end
      end
      S_DROP: begin
        // keep presenting the stale address until memory answers it
        imem.imem_req  = 1'b1;
        imem.imem_addr = drop_addr;
        if (pcsrc) pcf_n = target;
        if (imem.imem_ack) state_n = S_REQ;
      end
      default: state_n = S_IDLE;
    endcase

    if (pcsrc || flush_d) begin
      instrd_n  = BUBBLE;
      pcd_n     = '0;
      pcplus4_n = '0;
      valid_n   = 1'b0;
    end
  end

endmodule
